// File: rtl/line_buffer.sv
// line_buffer: keeps N-1 previous image rows and emits one vertical
// N-pixel column per accepted pixel. These columns feed an NxN window shift stage.
module line_buffer #(
  parameter int bits = 8,
  parameter int N    = 3,
  parameter int W    = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [bits-1:0]        in_pixel,
  input  logic                   frame_start,
  output logic [bits*N-1:0]      col_out,
  output logic                   out_valid,
  output logic                   window_valid,
  output logic [$clog2(W)-1:0]   col_idx
);

  localparam int CW = $clog2(W);
  localparam int RW = $clog2(N);

  localparam logic [CW-1:0] COL_LAST  = CW'(W - 1);
  localparam logic [CW-1:0] COL_FIRST = CW'(N - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(N - 1);

  // Line memories: mem[0] is the previous row, mem[N-2] is the oldest row.
  logic [bits-1:0] mem [N-1][W];

  logic [CW-1:0] col_cnt;
  logic [RW-1:0] row_cnt;

  // A frame_start pixel is forced to row 0, column 0 of a new frame.
  logic [CW-1:0] col_eff;
  logic [RW-1:0] row_eff;

  // Resolve the effective write position of the pixel offered this cycle.
  always_comb begin
    col_eff = col_cnt;
    row_eff = row_cnt;
    if (frame_start) begin
      col_eff = '0;
      row_eff = '0;
    end
  end

  // Vertical cascade through the line memories. This storage has no reset.
  // Stale contents are masked downstream by window_valid.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      mem[0][col_eff] <= in_pixel;
      for (int j = 1; j < N - 1; j++) begin
        mem[j][col_eff] <= mem[j-1][col_eff];
      end
    end
  end

  // Output column, status flags and raster position counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_out      <= '0;
      out_valid    <= 1'b0;
      window_valid <= 1'b0;
      col_idx      <= '0;
      col_cnt      <= '0;
      row_cnt      <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        col_out[bits*N-1 -: bits] <= in_pixel;
        for (int j = 1; j < N; j++) begin
          col_out[bits*(N-1-j) +: bits] <= mem[j-1][col_eff];
        end
        col_idx      <= col_eff;
        window_valid <= (row_eff == ROW_LAST) && (col_eff >= COL_FIRST);
        if (col_eff == COL_LAST) begin
          col_cnt <= '0;
          row_cnt <= (row_eff == ROW_LAST) ? row_eff : row_eff + 1'b1;
        end else begin
          col_cnt <= col_eff + 1'b1;
          row_cnt <= row_eff;
        end
      end
    end
  end

endmodule
